// File: rtl/vend_pkg.sv
// Shared vending constants: coin denominations, one-hot coin_sel bit positions
// and the change-dispense FSM state encoding.
package vend_pkg;

  localparam int DENOM_1  = 1;
  localparam int DENOM_5  = 5;
  localparam int DENOM_10 = 10;
  localparam int DENOM_20 = 20;
  localparam int DENOM_50 = 50;

  localparam int BIT_1  = 0;
  localparam int BIT_5  = 1;
  localparam int BIT_10 = 2;
  localparam int BIT_20 = 3;
  localparam int BIT_50 = 4;

  typedef logic [2:0] dispense_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Payout control/status and 4-phase ejector handshake bundle for change_dispense_ctrl.
interface change_dispense_ctrl_if #(
  parameter int MONEY_W = 8,
  parameter int CNT_W   = 4
);
  logic               start;
  logic [MONEY_W-1:0] change_in;
  logic               cancel;
  logic               eject_ack;
  logic               eject_req;
  logic [4:0]         coin_sel;
  logic [MONEY_W-1:0] remaining;
  logic [CNT_W-1:0]   coin_count;
  logic               busy;
  logic               done;
  logic               aborted;

  modport master (
    output start, change_in, cancel, eject_ack,
    input  eject_req, coin_sel, remaining, coin_count, busy, done, aborted
  );

  modport slave (
    input  start, change_in, cancel, eject_ack,
    output eject_req, coin_sel, remaining, coin_count, busy, done, aborted
  );
endinterface

// File: rtl/change_denom_select.sv
// Greedy coin picker: largest denomination not exceeding the amount still owed.
// Purely combinational so the display can reuse it as a "next coin" preview.
module change_denom_select
  import vend_pkg::*;
#(
  parameter int MONEY_W = 8
) (
  input  logic [MONEY_W-1:0] remaining,
  output logic [4:0]         coin_sel,
  output logic [MONEY_W-1:0] denom
);

  always_comb begin
    coin_sel = '0;
    denom    = '0;
    if (remaining >= MONEY_W'(DENOM_50)) begin
      coin_sel[BIT_50] = 1'b1;
      denom            = MONEY_W'(DENOM_50);
    end else if (remaining >= MONEY_W'(DENOM_20)) begin
      coin_sel[BIT_20] = 1'b1;
      denom            = MONEY_W'(DENOM_20);
    end else if (remaining >= MONEY_W'(DENOM_10)) begin
      coin_sel[BIT_10] = 1'b1;
      denom            = MONEY_W'(DENOM_10);
    end else if (remaining >= MONEY_W'(DENOM_5)) begin
      coin_sel[BIT_5] = 1'b1;
      denom           = MONEY_W'(DENOM_5);
    end else if (remaining >= MONEY_W'(DENOM_1)) begin
      coin_sel[BIT_1] = 1'b1;
      denom           = MONEY_W'(DENOM_1);
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: latches the owed amount on start and releases coins
// greedily, one per 4-phase req/ack handshake, with a minimum idle gap between coins.
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MONEY_W    = 8,
  parameter int GAP_CYCLES = 10_000_000,
  parameter int CNT_W      = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  change_dispense_ctrl_if.slave bus
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  dispense_state_t    state;
  logic [MONEY_W-1:0] remaining;
  logic [CNT_W-1:0]   coin_count;
  logic [4:0]         coin_sel;
  logic               aborted;
  logic               abort_pend;
  logic [GAP_W-1:0]   gap_cnt;
  logic [4:0]         next_sel;
  logic [MONEY_W-1:0] next_denom;
  logic               abort_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // remaining is frozen between SELECT and ack, so next_denom is the coin in flight
  change_denom_select #(.MONEY_W(MONEY_W)) u_denom_select (
    .remaining (remaining),
    .coin_sel  (next_sel),
    .denom     (next_denom)
  );

  assign abort_now = abort_pend | bus.cancel;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      coin_count <= '0;
      coin_sel   <= '0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      if (state != ST_IDLE && bus.cancel) abort_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            remaining  <= bus.change_in;
            coin_count <= '0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            state      <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (abort_now) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else if (remaining == '0) begin
            state <= ST_DONE;
          end else begin
            coin_sel <= next_sel;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.eject_ack) begin
            remaining  <= remaining - next_denom;
            coin_count <= sat_inc(coin_count);
            coin_sel   <= '0;
            state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!bus.eject_ack) begin
            if (abort_now) begin
              aborted <= 1'b1;
              state   <= ST_DONE;
            end else if (remaining == '0) begin
              state <= ST_DONE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (abort_now) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else if (gap_cnt == '0) begin
            state <= ST_SELECT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Request decoded from state so it falls the instant reset asserts
  assign bus.eject_req  = (state == ST_REQ);
  assign bus.coin_sel   = coin_sel;
  assign bus.remaining  = remaining;
  assign bus.coin_count = coin_count;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.aborted    = aborted;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scenario bench for change_dispense_ctrl: directed payouts plus randomized amounts
// and ack delays, checked against a greedy change-making model.
module tb_change_dispense_ctrl;

  localparam int MONEY_W    = 8;
  localparam int CNT_W      = 4;
  localparam int GAP_CYCLES = 4;

  logic sys_clk;
  logic sys_rst_n;

  change_dispense_ctrl_if #(.MONEY_W(MONEY_W), .CNT_W(CNT_W)) bus ();

  change_dispense_ctrl #(.MONEY_W(MONEY_W), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] obs_sel[$];
  int         obs_rem[$];
  logic [4:0] exp_sel[$];
  int         exp_rem[$];
  int exp_final;
  int obs_done, obs_done_k, obs_lat, obs_min_gap, obs_unstable, obs_timeout;
  int obs_busy_after, obs_count, obs_remaining, obs_aborted, obs_req_len;

  // Greedy change-making: stop_after < 0 means pay everything
  function automatic void model(input int amount, input int stop_after);
    int d[5];
    int rem;
    d = '{50, 20, 10, 5, 1};
    exp_sel.delete();
    exp_rem.delete();
    rem = amount;
    while (rem > 0 && (stop_after < 0 || exp_sel.size() < stop_after)) begin
      for (int i = 0; i < 5; i++) begin
        if (d[i] <= rem) begin
          exp_sel.push_back(5'b10000 >> i);
          exp_rem.push_back(rem);
          rem = rem - d[i];
          break;
        end
      end
    end
    exp_final = rem;
  endfunction

  function automatic logic [63:0] sig(input logic [4:0] q[$]);
    logic [63:0] s;
    s = 64'(q.size());
    foreach (q[i]) s = (s << 5) | 64'(q[i]);
    return s;
  endfunction

  // cancel_mode: 0 none, 1 during first REQ, 2 during first GAP
  task automatic do_payout(input int amount, input int ack_delay, input int cancel_mode, input bit restart);
    int k, req_cycles, last_fall, fall_cnt;
    logic [4:0] sel_rise;
    int rem_rise;
    bit req_prev, seen_done;
    obs_sel.delete(); obs_rem.delete();
    obs_done = 0; obs_done_k = -1; obs_lat = -1; obs_min_gap = 1000; obs_unstable = 0;
    obs_timeout = 0; obs_busy_after = 1; obs_req_len = 0;
    obs_count = -1; obs_remaining = -1; obs_aborted = -1;
    req_prev = 0; last_fall = -100; fall_cnt = 0; seen_done = 0; req_cycles = 0;
    sel_rise = '0; rem_rise = 0;
    @(negedge sys_clk);
    bus.start = 1'b1;
    bus.change_in = MONEY_W'(amount);
    @(negedge sys_clk);
    bus.start = 1'b0;
    bus.change_in = MONEY_W'($urandom_range(0, 255));
    k = 1;
    while (1) begin
      @(negedge sys_clk);
      k++;
      bus.cancel = 1'b0;
      bus.start  = 1'b0;
      if (bus.eject_req && !req_prev) begin
        obs_sel.push_back(bus.coin_sel);
        obs_rem.push_back(int'(bus.remaining));
        sel_rise = bus.coin_sel;
        rem_rise = int'(bus.remaining);
        req_cycles = 0;
        if (obs_lat < 0) obs_lat = k;
        if (fall_cnt > 0 && (k - last_fall) < obs_min_gap) obs_min_gap = k - last_fall;
        if (cancel_mode == 1 && obs_sel.size() == 1) bus.cancel = 1'b1;
      end
      if (bus.eject_req) begin
        req_cycles++;
        if (bus.coin_sel !== sel_rise || int'(bus.remaining) != rem_rise) obs_unstable++;
        if (req_cycles >= ack_delay) bus.eject_ack = 1'b1;
      end else if (req_prev) begin
        last_fall = k;
        fall_cnt++;
        obs_req_len = req_cycles;
        bus.eject_ack = 1'b0;
      end
      if (!bus.eject_req && fall_cnt == 1 && k == last_fall + 2 && !seen_done) begin
        if (cancel_mode == 2) bus.cancel = 1'b1;
        if (restart) begin
          bus.start = 1'b1;
          bus.change_in = MONEY_W'(10);
        end
      end
      if (bus.done) begin
        obs_done++;
        if (!seen_done) begin
          seen_done = 1;
          obs_done_k = k;
          obs_count = int'(bus.coin_count);
          obs_remaining = int'(bus.remaining);
          obs_aborted = int'(bus.aborted);
        end
      end
      if (seen_done && k == obs_done_k + 1) obs_busy_after = int'(bus.busy);
      if (seen_done && k >= obs_done_k + 4) break;
      if (k > 600) begin
        obs_timeout = 1;
        break;
      end
      req_prev = bus.eject_req;
    end
    bus.eject_ack = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    bus.start = 1'b0; bus.change_in = '0; bus.cancel = 1'b0; bus.eject_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (bus.eject_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.eject_req); end
    checks++; if (bus.coin_sel !== 5'd0) begin errors++; $display("FAIL reset_sel got %b want 0", bus.coin_sel); end
    checks++; if ({bus.busy, bus.done, bus.aborted} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.aborted}); end
    checks++; if (bus.remaining !== 8'd0 || bus.coin_count !== 4'd0) begin errors++; $display("FAIL reset_regs got rem %0d cnt %0d want 0 0", bus.remaining, bus.coin_count); end
    sys_rst_n = 1'b1;
    // cancel in IDLE must not leave anything pending for the next payout
    @(negedge sys_clk); bus.cancel = 1'b1;
    @(negedge sys_clk); bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_cancel_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_greedy_86();
    model(86, -1);
    do_payout(86, 1, 0, 0);
    checks++; if (obs_timeout != 0) begin errors++; $display("FAIL g86_timeout got %0d want 0", obs_timeout); end
    checks++; if (sig(obs_sel) !== sig(exp_sel)) begin errors++; $display("FAIL g86_coins got %h want %h", sig(obs_sel), sig(exp_sel)); end
    for (int i = 0; i < exp_rem.size() && i < obs_rem.size(); i++) begin
      checks++; if (obs_rem[i] != exp_rem[i]) begin errors++; $display("FAIL g86_rem%0d got %0d want %0d", i, obs_rem[i], exp_rem[i]); end
    end
    checks++; if (obs_count != 5) begin errors++; $display("FAIL g86_count got %0d want 5", obs_count); end
    checks++; if (obs_remaining != 0) begin errors++; $display("FAIL g86_remaining got %0d want 0", obs_remaining); end
    checks++; if (obs_done != 1) begin errors++; $display("FAIL g86_done_pulses got %0d want 1", obs_done); end
    checks++; if (obs_aborted != 0) begin errors++; $display("FAIL g86_aborted got %0d want 0", obs_aborted); end
    checks++; if (obs_lat != 2) begin errors++; $display("FAIL g86_latency got %0d want 2", obs_lat); end
    checks++; if (obs_busy_after != 0) begin errors++; $display("FAIL g86_busy_after got %0d want 0", obs_busy_after); end
  endtask

  task automatic test_zero();
    do_payout(0, 1, 0, 0);
    checks++; if (obs_done_k != 2) begin errors++; $display("FAIL zero_done_time got %0d want 2", obs_done_k); end
    checks++; if (obs_sel.size() != 0) begin errors++; $display("FAIL zero_req_count got %0d want 0", obs_sel.size()); end
    checks++; if (obs_count != 0 || obs_aborted != 0) begin errors++; $display("FAIL zero_final got cnt %0d ab %0d want 0 0", obs_count, obs_aborted); end
  endtask

  task automatic test_slow_ack();
    model(20, -1);
    do_payout(20, 7, 0, 0);
    checks++; if (sig(obs_sel) !== sig(exp_sel)) begin errors++; $display("FAIL slow_coins got %h want %h", sig(obs_sel), sig(exp_sel)); end
    checks++; if (obs_req_len != 7) begin errors++; $display("FAIL slow_req_len got %0d want 7", obs_req_len); end
    checks++; if (obs_unstable != 0) begin errors++; $display("FAIL slow_stable got %0d want 0", obs_unstable); end
    checks++; if (obs_remaining != 0 || obs_count != 1) begin errors++; $display("FAIL slow_final got rem %0d cnt %0d want 0 1", obs_remaining, obs_count); end
  endtask

  task automatic test_cancel(input int mode, input int amount);
    model(amount, 1);
    do_payout(amount, 1, mode, 0);
    checks++; if (sig(obs_sel) !== sig(exp_sel)) begin errors++; $display("FAIL cancel%0d_coins got %h want %h", mode, sig(obs_sel), sig(exp_sel)); end
    checks++; if (obs_remaining != exp_final) begin errors++; $display("FAIL cancel%0d_remaining got %0d want %0d", mode, obs_remaining, exp_final); end
    checks++; if (obs_count != 1 || obs_aborted != 1) begin errors++; $display("FAIL cancel%0d_final got cnt %0d ab %0d want 1 1", mode, obs_count, obs_aborted); end
    checks++; if (obs_done != 1) begin errors++; $display("FAIL cancel%0d_done got %0d want 1", mode, obs_done); end
  endtask

  task automatic test_reset_mid_req();
    int waited;
    @(negedge sys_clk); bus.start = 1'b1; bus.change_in = MONEY_W'(55);
    @(negedge sys_clk); bus.start = 1'b0;
    waited = 0;
    while (!bus.eject_req && waited < 10) begin
      @(negedge sys_clk);
      waited++;
    end
    checks++; if (bus.eject_req !== 1'b1) begin errors++; $display("FAIL rst_req_seen got %b want 1", bus.eject_req); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (bus.eject_req !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async got req %b busy %b want 0 0", bus.eject_req, bus.busy); end
    checks++; if (bus.remaining !== 8'd0) begin errors++; $display("FAIL rst_remaining got %0d want 0", bus.remaining); end
    @(negedge sys_clk); sys_rst_n = 1'b1;
    model(55, -1);
    do_payout(55, 2, 0, 0);
    checks++; if (sig(obs_sel) !== sig(exp_sel)) begin errors++; $display("FAIL rst_after_coins got %h want %h", sig(obs_sel), sig(exp_sel)); end
    checks++; if (obs_count != 2 || obs_remaining != 0) begin errors++; $display("FAIL rst_after_final got cnt %0d rem %0d want 2 0", obs_count, obs_remaining); end
  endtask

  task automatic test_back_to_back();
    model(255, -1);
    do_payout(255, 1, 0, 1);
    checks++; if (sig(obs_sel) !== sig(exp_sel)) begin errors++; $display("FAIL b2b_coins got %h want %h", sig(obs_sel), sig(exp_sel)); end
    checks++; if (obs_count != 6 || obs_remaining != 0) begin errors++; $display("FAIL b2b_final got cnt %0d rem %0d want 6 0", obs_count, obs_remaining); end
    checks++; if (obs_min_gap < GAP_CYCLES) begin errors++; $display("FAIL b2b_gap got %0d want >= %0d", obs_min_gap, GAP_CYCLES); end
    checks++; if (obs_done != 1 || obs_aborted != 0) begin errors++; $display("FAIL b2b_done got %0d ab %0d want 1 0", obs_done, obs_aborted); end
  endtask

  task automatic test_random();
    int amt, dly;
    for (int n = 0; n < 10; n++) begin
      amt = $urandom_range(0, 255);
      dly = $urandom_range(1, 3);
      model(amt, -1);
      do_payout(amt, dly, 0, 0);
      checks++; if (sig(obs_sel) !== sig(exp_sel)) begin errors++; $display("FAIL rnd%0d_coins amt %0d got %h want %h", n, amt, sig(obs_sel), sig(exp_sel)); end
      checks++; if (obs_count != exp_sel.size() || obs_remaining != 0) begin errors++; $display("FAIL rnd%0d_final amt %0d got cnt %0d rem %0d want %0d 0", n, amt, obs_count, obs_remaining, exp_sel.size()); end
      checks++; if (exp_sel.size() > 1 && obs_min_gap < GAP_CYCLES) begin errors++; $display("FAIL rnd%0d_gap got %0d want >= %0d", n, obs_min_gap, GAP_CYCLES); end
      checks++; if (obs_done != 1 || obs_aborted != 0 || obs_unstable != 0) begin errors++; $display("FAIL rnd%0d_flags got done %0d ab %0d unst %0d want 1 0 0", n, obs_done, obs_aborted, obs_unstable); end
    end
  endtask

  initial begin
    test_reset();
    test_greedy_86();
    test_zero();
    test_slow_ack();
    test_cancel(1, 100);
    test_cancel(2, 86);
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
